// File: rtl/mem_stage_access_pkg.sv
// Shared constants for the MEM stage: writeback-select codes and FSM state encoding.
package mem_stage_access_pkg;

    localparam logic [1:0] WD_SEL_ALU  = 2'b00;
    localparam logic [1:0] WD_SEL_DRAM = 2'b01;
    localparam logic [1:0] WD_SEL_WD   = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_access_pr_mem_wb.sv
// MEM/WB pipeline register; a bubble loads an empty slot instead of the incoming instruction.
module pr_MEM_WB (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_bubble,
    input  logic        i_rf_we,
    input  logic [4:0]  i_wR,
    input  logic [31:0] i_wb_data,
    input  logic [31:0] i_debug_pc,
    input  logic        i_have_inst,
    output logic        o_rf_we,
    output logic [4:0]  o_wR,
    output logic [31:0] o_wb_data,
    output logic [31:0] o_debug_pc,
    output logic        o_have_inst
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rf_we     <= 1'b0;
            o_wR        <= '0;
            o_wb_data   <= '0;
            o_debug_pc  <= '0;
            o_have_inst <= 1'b0;
        end else if (i_bubble) begin
            o_rf_we     <= 1'b0;
            o_wR        <= '0;
            o_wb_data   <= '0;
            o_debug_pc  <= '0;
            o_have_inst <= 1'b0;
        end else begin
            o_rf_we     <= i_rf_we;
            o_wR        <= i_wR;
            o_wb_data   <= i_wb_data;
            o_debug_pc  <= i_debug_pc;
            o_have_inst <= i_have_inst;
        end
    end

endmodule

// File: rtl/mem_stage_access.sv
// MEM stage: data-RAM req/ack access with stall and timeout, writeback mux, MEM/WB register.
// state | meaning
// IDLE  | no access outstanding; non-memory ops and zero-wait accesses pass straight to MEM/WB
// BUSY  | access outstanding, request driven from captured regs, pipeline stalled
module mem_stage_access
    import mem_stage_access_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  wd_sel_i,
    input  logic        rf_we_i,
    input  logic        dram_we_i,
    input  logic [4:0]  wR_i,
    input  logic [31:0] wD_i,
    input  logic [31:0] aluc_i,
    input  logic [31:0] rd2_i,
    input  logic [31:0] debug_pc_i,
    input  logic        debug_have_inst_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        rf_we_o,
    output logic [4:0]  wR_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] debug_pc_o,
    output logic        debug_have_inst_o,
    output logic        bus_err_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    state_t      r_state;
    logic [1:0]  r_wd_sel;
    logic        r_rf_we;
    logic        r_we;
    logic [4:0]  r_wR;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic [CW-1:0] r_cnt;
    logic        r_bus_err;

    logic        w_busy;
    logic        w_access;
    logic        w_timeout;
    logic        w_done;
    logic        w_req;
    logic        w_stall;
    logic [1:0]  w_sel;
    logic        w_we;
    logic [31:0] w_alu;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;

    assign w_busy    = (r_state == BUSY);
    assign w_access  = debug_have_inst_i & (dram_we_i | (wd_sel_i == WD_SEL_DRAM));
    // The last BUSY cycle still honours an ack; only an unanswered one is a timeout.
    assign w_timeout = w_busy & (r_cnt == TO_LAST) & ~mem_ack_i;
    assign w_done    = w_busy & (mem_ack_i | (r_cnt == TO_LAST));
    assign w_req     = rst_n & ((~w_busy & w_access) | w_busy);
    assign w_stall   = (~w_busy & w_access & ~mem_ack_i) | (w_busy & ~w_done);

    assign mem_req_o   = w_req;
    assign mem_we_o    = w_req & (w_busy ? r_we : dram_we_i);
    assign mem_addr_o  = w_req ? (w_busy ? r_addr : aluc_i) : 32'h0;
    assign mem_wdata_o = w_req ? (w_busy ? r_wdata : rd2_i) : 32'h0;
    assign stall_o     = rst_n & w_stall;
    assign bus_err_o   = r_bus_err;

    assign w_sel       = w_busy ? r_wd_sel : wd_sel_i;
    assign w_we        = w_busy ? r_we : dram_we_i;
    assign w_alu       = w_busy ? r_addr : aluc_i;
    assign w_load_data = w_timeout ? 32'h0 : mem_rdata_i;

    always_comb begin
        w_wb_data = w_alu;
        if (!w_we && w_sel == WD_SEL_DRAM) begin
            w_wb_data = w_load_data;
        end else if (w_sel == WD_SEL_WD) begin
            w_wb_data = wD_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wd_sel  <= WD_SEL_ALU;
            r_rf_we   <= 1'b0;
            r_we      <= 1'b0;
            r_wR      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access && !mem_ack_i) begin
                        r_state  <= BUSY;
                        r_wd_sel <= wd_sel_i;
                        r_rf_we  <= rf_we_i;
                        r_we     <= dram_we_i;
                        r_wR     <= wR_i;
                        r_addr   <= aluc_i;
                        r_wdata  <= rd2_i;
                        r_pc     <= debug_pc_i;
                        r_cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        if (w_timeout) begin
                            r_bus_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    pr_MEM_WB u_pr_mem_wb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_bubble    (w_stall),
        .i_rf_we     (w_busy ? r_rf_we : (rf_we_i & debug_have_inst_i)),
        .i_wR        (w_busy ? r_wR : wR_i),
        .i_wb_data   (w_wb_data),
        .i_debug_pc  (w_busy ? r_pc : debug_pc_i),
        .i_have_inst (w_busy | debug_have_inst_i),
        .o_rf_we     (rf_we_o),
        .o_wR        (wR_o),
        .o_wb_data   (wb_data_o),
        .o_debug_pc  (debug_pc_o),
        .o_have_inst (debug_have_inst_o)
    );

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access; completions are checked against a queue of expected writebacks.
module tb_mem_stage_access;
    import mem_stage_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  wd_sel_i;
    logic        rf_we_i;
    logic        dram_we_i;
    logic [4:0]  wR_i;
    logic [31:0] wD_i;
    logic [31:0] aluc_i;
    logic [31:0] rd2_i;
    logic [31:0] debug_pc_i;
    logic        debug_have_inst_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  wR_o;
    logic [31:0] wb_data_o;
    logic [31:0] debug_pc_o;
    logic        debug_have_inst_o;
    logic        bus_err_o;

    always #5 clk = ~clk;

    mem_stage_access #(.TIMEOUT_CYC(15)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wd_sel_i          (wd_sel_i),
        .rf_we_i           (rf_we_i),
        .dram_we_i         (dram_we_i),
        .wR_i              (wR_i),
        .wD_i              (wD_i),
        .aluc_i            (aluc_i),
        .rd2_i             (rd2_i),
        .debug_pc_i        (debug_pc_i),
        .debug_have_inst_i (debug_have_inst_i),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_ack_i         (mem_ack_i),
        .mem_rdata_i       (mem_rdata_i),
        .stall_o           (stall_o),
        .rf_we_o           (rf_we_o),
        .wR_o              (wR_o),
        .wb_data_o         (wb_data_o),
        .debug_pc_o        (debug_pc_o),
        .debug_have_inst_o (debug_have_inst_o),
        .bus_err_o         (bus_err_o)
    );

    typedef struct {
        logic [4:0]  wr;
        logic [31:0] data;
        logic        rf_we;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   nstall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] wr, input logic [31:0] data, input logic rfwe,
                        input logic [31:0] pc);
        exp_t e;
        e.wr = wr; e.data = data; e.rf_we = rfwe; e.pc = pc;
        sb.push_back(e);
    endtask

    // Advance one clock; any real instruction leaving MEM/WB is matched against the queue head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (debug_have_inst_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", 32'(debug_have_inst_o), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_wR", 32'(wR_o), 32'(e.wr));
                chk("wb_data", wb_data_o, e.data);
                chk("wb_rf_we", 32'(rf_we_o), 32'(e.rf_we));
                chk("wb_pc", debug_pc_o, e.pc);
            end
        end
    endtask

    task automatic drive(input logic have, input logic [1:0] sel, input logic rfwe,
                         input logic dwe, input logic [4:0] wr, input logic [31:0] alu,
                         input logic [31:0] rd2, input logic [31:0] wd, input logic [31:0] pc);
        debug_have_inst_i = have;
        wd_sel_i          = sel;
        rf_we_i           = rfwe;
        dram_we_i         = dwe;
        wR_i              = wr;
        aluc_i            = alu;
        rd2_i             = rd2;
        wD_i              = wd;
        debug_pc_i        = pc;
    endtask

    task automatic idle_in();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_rf_we", 32'(rf_we_o), 32'd0);
        chk("rst_wb_data", wb_data_o, 32'h0);
        chk("rst_have_inst", 32'(debug_have_inst_o), 32'd0);
        chk("rst_bus_err", 32'(bus_err_o), 32'd0);
        rst_n = 1'b1;

        // plain ALU op
        drive(1'b1, WD_SEL_ALU, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h40);
        #1;
        chk("alu_stall", 32'(stall_o), 32'd0);
        chk("alu_req", 32'(mem_req_o), 32'd0);
        push(5'd5, 32'h1234, 1'b1, 32'h40);
        tick();

        drive(1'b1, WD_SEL_WD, 1'b1, 1'b0, 5'd6, 32'h999, 32'h0, 32'h55, 32'h44);
        push(5'd6, 32'h55, 1'b1, 32'h44);
        tick();

        drive(1'b1, 2'b11, 1'b1, 1'b0, 5'd8, 32'h777, 32'h0, 32'h66, 32'h48);
        push(5'd8, 32'h777, 1'b1, 32'h48);
        tick();

        // no instruction in the slot: write enable must be masked
        drive(1'b0, WD_SEL_ALU, 1'b1, 1'b0, 5'd3, 32'hAAA, 32'h0, 32'h0, 32'h4C);
        tick();
        chk("noinst_rf_we", 32'(rf_we_o), 32'd0);

        // zero-wait load
        drive(1'b1, WD_SEL_DRAM, 1'b1, 1'b0, 5'd10, 32'h100, 32'h0, 32'h0, 32'h50);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEADBEEF;
        #1;
        chk("ld0_req", 32'(mem_req_o), 32'd1);
        chk("ld0_we", 32'(mem_we_o), 32'd0);
        chk("ld0_addr", mem_addr_o, 32'h100);
        chk("ld0_stall", 32'(stall_o), 32'd0);
        push(5'd10, 32'hDEADBEEF, 1'b1, 32'h50);
        tick();
        mem_ack_i = 1'b0;
        idle_in();
        #1;
        chk("ld0_req_drop", 32'(mem_req_o), 32'd0);

        // store acked on the 4th request cycle; upstream changes while BUSY
        nstall = 0;
        drive(1'b1, WD_SEL_ALU, 1'b0, 1'b1, 5'd7, 32'h200, 32'hA5A5A5A5, 32'h0, 32'h54);
        #1;
        chk("st_req0", 32'(mem_req_o), 32'd1);
        chk("st_we0", 32'(mem_we_o), 32'd1);
        chk("st_wdata0", mem_wdata_o, 32'hA5A5A5A5);
        if (stall_o === 1'b1) nstall++;
        tick();
        chk("st_bubble0", 32'(debug_have_inst_o), 32'd0);
        drive(1'b1, WD_SEL_ALU, 1'b1, 1'b0, 5'd1, 32'hFFFF0000, 32'h0, 32'h0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) begin
                mem_ack_i = 1'b1;
                push(5'd7, 32'h200, 1'b0, 32'h54);
            end
            #1;
            chk("st_req", 32'(mem_req_o), 32'd1);
            chk("st_addr", mem_addr_o, 32'h200);
            chk("st_wdata", mem_wdata_o, 32'hA5A5A5A5);
            chk("st_we", 32'(mem_we_o), 32'd1);
            if (stall_o === 1'b1) nstall++;
            tick();
            if (i < 3) chk("st_bubble", 32'(debug_have_inst_o), 32'd0);
        end
        chk("st_stall_cycles", 32'(nstall), 32'd3);

        // back-to-back load issued right after the store completes
        drive(1'b1, WD_SEL_DRAM, 1'b1, 1'b0, 5'd11, 32'h104, 32'h0, 32'h0, 32'h58);
        mem_rdata_i = 32'h12345678;
        #1;
        chk("b2b_req", 32'(mem_req_o), 32'd1);
        chk("b2b_addr", mem_addr_o, 32'h104);
        push(5'd11, 32'h12345678, 1'b1, 32'h58);
        tick();
        mem_ack_i = 1'b0;
        idle_in();

        // ack lands in the same cycle the timeout would fire
        drive(1'b1, WD_SEL_DRAM, 1'b1, 1'b0, 5'd12, 32'h300, 32'h0, 32'h0, 32'h60);
        tick();
        idle_in();
        for (int i = 1; i <= 15; i++) begin
            if (i == 15) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = 32'hCAFEF00D;
                push(5'd12, 32'hCAFEF00D, 1'b1, 32'h60);
            end
            #1;
            chk("lastack_stall", 32'(stall_o), 32'(i < 15));
            tick();
        end
        mem_ack_i = 1'b0;
        chk("lastack_no_err", 32'(bus_err_o), 32'd0);

        // load never acked -> timeout
        nstall = 0;
        drive(1'b1, WD_SEL_DRAM, 1'b1, 1'b0, 5'd13, 32'h400, 32'h0, 32'h0, 32'h64);
        mem_rdata_i = 32'h77777777;
        #1;
        if (stall_o === 1'b1) nstall++;
        tick();
        idle_in();
        for (int i = 1; i <= 15; i++) begin
            if (i == 15) push(5'd13, 32'h0, 1'b1, 32'h64);
            #1;
            chk("to_req", 32'(mem_req_o), 32'd1);
            if (stall_o === 1'b1) nstall++;
            tick();
        end
        chk("to_stall_cycles", 32'(nstall), 32'd15);
        chk("to_bus_err", 32'(bus_err_o), 32'd1);
        chk("to_req_drop", 32'(mem_req_o), 32'd0);
        drive(1'b1, WD_SEL_ALU, 1'b1, 1'b0, 5'd2, 32'h5A, 32'h0, 32'h0, 32'h68);
        push(5'd2, 32'h5A, 1'b1, 32'h68);
        tick();
        idle_in();
        chk("bus_err_sticky", 32'(bus_err_o), 32'd1);

        // reset pulsed while BUSY
        drive(1'b1, WD_SEL_DRAM, 1'b1, 1'b0, 5'd14, 32'h500, 32'h0, 32'h0, 32'h6C);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstb_req", 32'(mem_req_o), 32'd0);
        chk("rstb_stall", 32'(stall_o), 32'd0);
        chk("rstb_bus_err", 32'(bus_err_o), 32'd0);
        chk("rstb_rf_we", 32'(rf_we_o), 32'd0);
        chk("rstb_have_inst", 32'(debug_have_inst_o), 32'd0);
        chk("rstb_wR", 32'(wR_o), 32'd0);
        idle_in();
        tick();
        rst_n       = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBADBAD00;
        #1;
        chk("stale_ack_req", 32'(mem_req_o), 32'd0);
        tick();
        chk("stale_ack_ignored", 32'(debug_have_inst_o), 32'd0);
        mem_ack_i = 1'b0;
        drive(1'b1, WD_SEL_ALU, 1'b1, 1'b0, 5'd15, 32'hBEEF, 32'h0, 32'h0, 32'h70);
        push(5'd15, 32'hBEEF, 1'b1, 32'h70);
        tick();
        idle_in();
        chk("post_rst_bus_err", 32'(bus_err_o), 32'd0);

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
